// File: rtl/core2axi_pkg.sv
// core2axi_pkg: shared AXI encodings and channel-struct typedef macros for the
// core-to-AXI bridge.
// No ports. Provides response codes, AxPROT/AxBURST encodings, an error
// decode helper, and the macros that build the AX and W payload structs.

`define CORE2AXI_TYPEDEF_AX_CHAN_T(chan_t, addr_t, id_t, user_t) \
  typedef struct packed {                                        \
    id_t         id;                                             \
    addr_t       addr;                                           \
    logic [7:0]  len;                                            \
    logic [2:0]  size;                                           \
    logic [1:0]  burst;                                          \
    logic        lock;                                           \
    logic [3:0]  cache;                                          \
    logic [2:0]  prot;                                           \
    logic [3:0]  qos;                                            \
    logic [3:0]  region;                                         \
    user_t       user;                                           \
  } chan_t;

`define CORE2AXI_TYPEDEF_W_CHAN_T(chan_t, data_t, strb_t, user_t) \
  typedef struct packed {                                        \
    data_t data;                                                 \
    strb_t strb;                                                 \
    logic  last;                                                 \
    user_t user;                                                 \
  } chan_t;

package core2axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_UNPRIV_SECURE_DATA = 3'b000;
  localparam logic [2:0] PROT_PRIVILEGED         = 3'b001;
  localparam logic [2:0] PROT_NONSECURE          = 3'b010;
  localparam logic [2:0] PROT_INSTRUCTION        = 3'b100;

  localparam logic [1:0] BURST_INCR = 2'b01;

  // SLVERR and DECERR both have bit 1 set; OKAY/EXOKAY do not.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/axi_bus.sv
// AXI_BUS: AXI4 bus interface bundle with Master and Slave modports.
// Parameters set address, data, ID and user widths; strobe width is DATA/8.

interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 16,
  parameter int unsigned AXI_USER_WIDTH = 10
);
  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_qos;
  logic [3:0]                aw_region;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]         w_strb;
  logic                      w_last;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_valid;
  logic                      w_ready;

  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_qos;
  logic [3:0]                ar_region;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid, input aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid, input w_ready,
    input b_id, b_resp, b_user, b_valid, output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid, input ar_ready,
    input r_id, r_data, r_resp, r_last, r_user, r_valid, output r_ready
  );

  modport Slave (
    input aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
          aw_qos, aw_region, aw_user, aw_valid, output aw_ready,
    input w_data, w_strb, w_last, w_user, w_valid, output w_ready,
    output b_id, b_resp, b_user, b_valid, input b_ready,
    input ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
          ar_qos, ar_region, ar_user, ar_valid, output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid, input r_ready
  );
endinterface

// File: rtl/core2axi_order_fifo.sv
// core2axi_order_fifo: small synchronous FIFO remembering request order.
// Ports: clk_i/rst_ni, push_i + wdata_i, pop_i, rdata_o (head entry),
// full_o, empty_o. Push while full and pop while empty are ignored.

module core2axi_order_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             push_s, pop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : ptr + PTR_W'(1);
  endfunction

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == CNT_W'(0));
  assign push_s  = push_i & ~full_o;
  assign pop_s   = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_s) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_s, pop_s})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/core2axi_mo.sv
// core2axi_mo: bridges a req/gnt/rvalid core data port to a single-beat AXI4
// master with up to MAX_OUTSTANDING transactions in flight.
// Ports: clk_i, rst_ni; core side data_req_i/data_gnt_o, data_addr_i,
// data_we_i, data_be_i, data_wdata_i, data_rvalid_o, data_rdata_o,
// data_err_o; AXI_Master (AXI_BUS.Master). Responses are returned in request
// order by back-pressuring whichever response channel is not at the head.

module core2axi_mo
  import core2axi_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH  = 32,
  parameter int unsigned AXI_DATA_WIDTH  = 32,
  parameter int unsigned AXI_ID_WIDTH    = 16,
  parameter int unsigned AXI_USER_WIDTH  = 10,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned AXI_ID          = 0,
  parameter logic [2:0]  AXI_PROT        = 3'b000
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        data_req_i,
  output logic                        data_gnt_o,
  input  logic [AXI_ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                        data_we_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] data_be_i,
  input  logic [AXI_DATA_WIDTH-1:0]   data_wdata_i,
  output logic                        data_rvalid_o,
  output logic [AXI_DATA_WIDTH-1:0]   data_rdata_o,
  output logic                        data_err_o,
  AXI_BUS.Master                      AXI_Master
);
  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
  localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);

  typedef logic [AXI_ADDR_WIDTH-1:0] addr_t;
  typedef logic [AXI_DATA_WIDTH-1:0] data_t;
  typedef logic [STRB_W-1:0]         strb_t;
  typedef logic [AXI_ID_WIDTH-1:0]   id_t;
  typedef logic [AXI_USER_WIDTH-1:0] user_t;
  `CORE2AXI_TYPEDEF_AX_CHAN_T(ax_chan_t, addr_t, id_t, user_t)
  `CORE2AXI_TYPEDEF_W_CHAN_T(w_chan_t, data_t, strb_t, user_t)

  ax_chan_t         ax_s;
  w_chan_t          w_s;
  logic             active_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic             ar_pend_q, aw_pend_q, w_pend_q;
  logic             not_full_s, ar_valid_s, aw_valid_s, w_valid_s;
  logic             ar_hs_s, aw_hs_s, w_hs_s, wr_gnt_s, gnt_s;
  logic             r_ready_s, b_ready_s, r_hs_s, b_hs_s, rsp_hs_s;
  logic [0:0]       head_we_s;
  logic             fifo_empty_s, fifo_full_unused_s;
  logic             rvalid_q, err_q;
  data_t            rdata_q;
  logic             unused_s;

  // Both address channels share one payload; the core holds it until grant.
  assign ax_s = '{id: id_t'(AXI_ID), addr: data_addr_i, len: 8'd0,
                  size: 3'($clog2(STRB_W)), burst: BURST_INCR, lock: 1'b0,
                  cache: 4'd0, prot: AXI_PROT, qos: 4'd0, region: 4'd0, user: '0};
  assign w_s  = '{data: data_wdata_i, strb: data_be_i, last: 1'b1, user: '0};

  assign not_full_s = (cnt_q < CNT_W'(MAX_OUTSTANDING));

  // Channel valids, handshakes, grant and outstanding-counter next state.
  // A pending VALID ignores the counter so it can never be withdrawn.
  always_comb begin
    ar_valid_s = active_q & data_req_i & ~data_we_i & (not_full_s | ar_pend_q);
    aw_valid_s = active_q & data_req_i & data_we_i & ~aw_done_q & (not_full_s | aw_pend_q);
    w_valid_s  = active_q & data_req_i & data_we_i & ~w_done_q & (not_full_s | w_pend_q);
    ar_hs_s    = ar_valid_s & AXI_Master.ar_ready;
    aw_hs_s    = aw_valid_s & AXI_Master.aw_ready;
    w_hs_s     = w_valid_s & AXI_Master.w_ready;
    wr_gnt_s   = (aw_done_q | aw_hs_s) & (w_done_q | w_hs_s);
    gnt_s      = ar_hs_s | wr_gnt_s;
    aw_done_d  = wr_gnt_s ? 1'b0 : (aw_done_q | aw_hs_s);
    w_done_d   = wr_gnt_s ? 1'b0 : (w_done_q | w_hs_s);

    r_ready_s  = active_q & ~fifo_empty_s & ~head_we_s[0];
    b_ready_s  = active_q & ~fifo_empty_s & head_we_s[0];
    r_hs_s     = r_ready_s & AXI_Master.r_valid;
    b_hs_s     = b_ready_s & AXI_Master.b_valid;
    rsp_hs_s   = r_hs_s | b_hs_s;

    case ({gnt_s, rsp_hs_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state and registered core response.
  // active_q holds every VALID/READY low until the first clock after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q  <= 1'b0;
      cnt_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      ar_pend_q <= 1'b0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      active_q  <= 1'b1;
      cnt_q     <= cnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      ar_pend_q <= ar_valid_s & ~AXI_Master.ar_ready;
      aw_pend_q <= aw_valid_s & ~AXI_Master.aw_ready;
      w_pend_q  <= w_valid_s & ~AXI_Master.w_ready;
      rvalid_q  <= rsp_hs_s;
      rdata_q   <= r_hs_s ? AXI_Master.r_data : '0;
      err_q     <= r_hs_s ? resp_is_err(AXI_Master.r_resp)
                          : (b_hs_s & resp_is_err(AXI_Master.b_resp));
    end
  end

  core2axi_order_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (1)
  ) i_order_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (gnt_s),
    .wdata_i (data_we_i),
    .pop_i   (rsp_hs_s),
    .rdata_o (head_we_s),
    .full_o  (fifo_full_unused_s),
    .empty_o (fifo_empty_s)
  );

  assign data_gnt_o    = gnt_s;
  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;
  assign data_err_o    = err_q;

  assign AXI_Master.aw_id     = ax_s.id;
  assign AXI_Master.aw_addr   = ax_s.addr;
  assign AXI_Master.aw_len    = ax_s.len;
  assign AXI_Master.aw_size   = ax_s.size;
  assign AXI_Master.aw_burst  = ax_s.burst;
  assign AXI_Master.aw_lock   = ax_s.lock;
  assign AXI_Master.aw_cache  = ax_s.cache;
  assign AXI_Master.aw_prot   = ax_s.prot;
  assign AXI_Master.aw_qos    = ax_s.qos;
  assign AXI_Master.aw_region = ax_s.region;
  assign AXI_Master.aw_user   = ax_s.user;
  assign AXI_Master.aw_valid  = aw_valid_s;
  assign AXI_Master.w_data    = w_s.data;
  assign AXI_Master.w_strb    = w_s.strb;
  assign AXI_Master.w_last    = w_s.last;
  assign AXI_Master.w_user    = w_s.user;
  assign AXI_Master.w_valid   = w_valid_s;
  assign AXI_Master.b_ready   = b_ready_s;
  assign AXI_Master.ar_id     = ax_s.id;
  assign AXI_Master.ar_addr   = ax_s.addr;
  assign AXI_Master.ar_len    = ax_s.len;
  assign AXI_Master.ar_size   = ax_s.size;
  assign AXI_Master.ar_burst  = ax_s.burst;
  assign AXI_Master.ar_lock   = ax_s.lock;
  assign AXI_Master.ar_cache  = ax_s.cache;
  assign AXI_Master.ar_prot   = ax_s.prot;
  assign AXI_Master.ar_qos    = ax_s.qos;
  assign AXI_Master.ar_region = ax_s.region;
  assign AXI_Master.ar_user   = ax_s.user;
  assign AXI_Master.ar_valid  = ar_valid_s;
  assign AXI_Master.r_ready   = r_ready_s;

  // IDs, user fields, LAST and the low response bit carry no information here.
  assign unused_s = ^{AXI_Master.r_id, AXI_Master.r_last, AXI_Master.r_user,
                      AXI_Master.b_id, AXI_Master.b_user, fifo_full_unused_s};
endmodule
